// File: rtl/rf_pkg.sv
// Shared defaults for the multi-ported register file and its scoreboard.
package rf_pkg;

  localparam int unsigned XlenDef  = 32;
  localparam int unsigned NregsDef = 32;
  localparam int unsigned NrdDef   = 2;
  localparam int unsigned NwrDef   = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bit per register, set on issue, cleared on write,
// plus a sticky flag for same-cycle dual writes to one register.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NregsDef,
  parameter int unsigned NWR   = NwrDef,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_i,
  input  logic [AW-1:0]           alloc_a_i,
  input  logic [NWR-1:0]          we_i,
  input  logic [NWR-1:0][AW-1:0]  wa_i,
  output logic [NREGS-1:0]        busy_o,
  output logic                    wcol_o
);

  logic [NREGS-1:0] busy_d, busy_q;
  logic             wcol_d, wcol_q;
  logic             collide;

  // Clears first so that a same-cycle allocation of the written register wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k]) busy_d[wa_i[k]] = 1'b0;
    end
    if (alloc_i) busy_d[alloc_a_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    collide = 1'b0;
    if (NWR > 1) begin
      collide = we_i[0] & we_i[NWR-1] & (wa_i[0] == wa_i[NWR-1]) & (wa_i[0] != '0);
    end
    wcol_d = wcol_q | collide;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      wcol_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wcol_q <= wcol_d;
    end
  end

  assign busy_o = busy_q;
  assign wcol_o = wcol_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with write-first bypass and an issue scoreboard.
// Register 0 is hardwired to zero; the highest-indexed write port wins on conflicts.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XlenDef,
  parameter int unsigned NREGS = NregsDef,
  parameter int unsigned NRD   = NrdDef,
  parameter int unsigned NWR   = NwrDef,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRD-1:0][AW-1:0]   ra_i,
  output logic [NRD-1:0][XLEN-1:0] rd_o,
  output logic [NRD-1:0]           rbusy_o,
  input  logic [NWR-1:0]           we_i,
  input  logic [NWR-1:0][AW-1:0]   wa_i,
  input  logic [NWR-1:0][XLEN-1:0] wd_i,
  input  logic                     alloc_i,
  input  logic [AW-1:0]            alloc_a_i,
  output logic [NREGS-1:0]         busy_o,
  output logic                     wcol_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NRD-1:0]  hit;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .alloc_i   (alloc_i),
    .alloc_a_i (alloc_a_i),
    .we_i      (we_i),
    .wa_i      (wa_i),
    .busy_o    (busy_o),
    .wcol_o    (wcol_o)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k] && (wa_i[k] != '0)) regs_d[wa_i[k]] = wd_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass is suppressed under reset: the write it would forward is being discarded.
  always_comb begin
    rd_o    = '0;
    rbusy_o = '0;
    hit     = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_o[p] = regs_q[ra_i[p]];
      for (int k = 0; k < NWR; k++) begin
        if (rst_ni && we_i[k] && (wa_i[k] == ra_i[p])) begin
          hit[p]  = 1'b1;
          rd_o[p] = wd_i[k];
        end
      end
      if (ra_i[p] == '0) rd_o[p] = '0;
      rbusy_o[p] = busy_o[ra_i[p]] & ~hit[p];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: array model checked every cycle plus literal expectations.
module tb_reg_file_mp;

  localparam int unsigned XL = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned NP = 2;
  localparam int unsigned NW = 2;
  localparam int unsigned AW = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NP-1:0][AW-1:0]  ra;
  logic [NP-1:0][XL-1:0]  rd;
  logic [NP-1:0]          rbusy;
  logic [NW-1:0]          we;
  logic [NW-1:0][AW-1:0]  wa;
  logic [NW-1:0][XL-1:0]  wd;
  logic                   alloc;
  logic [AW-1:0]          alloc_a;
  logic [NR-1:0]          busy;
  logic                   wcol;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  reg_file_mp #(
    .XLEN  (XL),
    .NREGS (NR),
    .NRD   (NP),
    .NWR   (NW)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ra_i      (ra),
    .rd_o      (rd),
    .rbusy_o   (rbusy),
    .we_i      (we),
    .wa_i      (wa),
    .wd_i      (wd),
    .alloc_i   (alloc),
    .alloc_a_i (alloc_a),
    .busy_o    (busy),
    .wcol_o    (wcol)
  );

  // Behavioural model: architectural register contents, pending set and collision flag.
  logic [XL-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_wcol;
  logic          chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_regs[i] <= '0;
      m_busy <= '0;
      m_wcol <= 1'b0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we[k]) begin
          if (wa[k] != 0) m_regs[wa[k]] <= wd[k];
          m_busy[wa[k]] <= 1'b0;
        end
      end
      if (we == 2'b11 && wa[0] == wa[1] && wa[0] != 0) m_wcol <= 1'b1;
      if (alloc && alloc_a != 0) m_busy[alloc_a] <= 1'b1;
    end
  end

  function automatic logic [XL-1:0] exp_rd(input int p);
    logic [XL-1:0] e;
    e = (ra[p] == 0) ? '0 : m_regs[ra[p]];
    if (rst_n && ra[p] != 0) begin
      for (int k = 0; k < NW; k++) if (we[k] && wa[k] == ra[p]) e = wd[k];
    end
    return e;
  endfunction

  function automatic logic exp_rbusy(input int p);
    logic h;
    h = 1'b0;
    for (int k = 0; k < NW; k++) if (rst_n && we[k] && wa[k] == ra[p]) h = 1'b1;
    return m_busy[ra[p]] & ~h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("model rd[%0d]", p), 64'(rd[p]), 64'(exp_rd(p)));
        check($sformatf("model rbusy[%0d]", p), 64'(rbusy[p]), 64'(exp_rbusy(p)));
      end
      check("model busy", 64'(busy), 64'(m_busy));
      check("model wcol", 64'(wcol), 64'(m_wcol));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; alloc = 1'b0; alloc_a = '0;
  endtask

  initial begin
    idle();
    ra = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Fresh state reads zero everywhere
    for (int a = 0; a < NR; a++) begin
      ra[0] = AW'(a);
      ra[1] = AW'(NR - 1 - a);
      @(negedge clk);
      if (a % 8 == 0) begin
        check("reset rd0", 64'(rd[0]), 64'h0);
        check("reset rd1", 64'(rd[1]), 64'h0);
      end
      nxt();
    end
    check("reset busy", 64'(busy), 64'h0);
    check("reset wcol", 64'(wcol), 64'h0);

    // Bypass then storage
    we[0] = 1'b1; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5;
    @(negedge clk); check("bypass rd0", 64'(rd[0]), 64'hDEADBEEF);
    nxt(); idle();
    @(negedge clk); check("stored rd0", 64'(rd[0]), 64'hDEADBEEF);

    // Port 1 write, read on port 1
    nxt(); we[1] = 1'b1; wa[1] = 12; wd[1] = 32'hCAFE0012; ra[1] = 12;
    @(negedge clk); check("bypass rd1", 64'(rd[1]), 64'hCAFE0012);
    nxt(); idle();
    @(negedge clk); check("stored rd1", 64'(rd[1]), 64'hCAFE0012);

    // Writes to register 0 are dropped
    nxt(); we[0] = 1'b1; wa[0] = 0; wd[0] = 32'h12345678; ra[0] = 0;
    @(negedge clk); check("r0 bypass", 64'(rd[0]), 64'h0);
    nxt(); idle();
    @(negedge clk); check("r0 stored", 64'(rd[0]), 64'h0);
    check("r0 busy", 64'(busy[0]), 64'h0);

    // Dual write collision
    nxt(); we = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    ra[0] = 7;
    @(negedge clk); check("wcol bypass", 64'(rd[0]), 64'h22222222);
    check("wcol pre", 64'(wcol), 64'h0);
    nxt(); idle();
    @(negedge clk); check("wcol stored", 64'(rd[0]), 64'h22222222);
    check("wcol set", 64'(wcol), 64'h1);
    repeat (3) nxt();
    @(negedge clk); check("wcol sticky", 64'(wcol), 64'h1);

    // Scoreboard
    nxt(); alloc = 1'b1; alloc_a = 3;
    nxt(); idle(); ra[0] = 3;
    @(negedge clk); check("alloc busy3", 64'(busy[3]), 64'h1);
    check("alloc rbusy", 64'(rbusy[0]), 64'h1);
    nxt(); we[0] = 1'b1; wa[0] = 3; wd[0] = 32'hAAAA0003;
    @(negedge clk); check("write rbusy", 64'(rbusy[0]), 64'h0);
    check("write busy3 pre", 64'(busy[3]), 64'h1);
    nxt(); idle();
    @(negedge clk); check("write busy3 post", 64'(busy[3]), 64'h0);
    check("write rd", 64'(rd[0]), 64'hAAAA0003);
    nxt(); alloc = 1'b1; alloc_a = 3; we[0] = 1'b1; wa[0] = 3; wd[0] = 32'hBBBB0003;
    nxt(); idle();
    @(negedge clk); check("alloc+write busy3", 64'(busy[3]), 64'h1);
    check("alloc+write rd", 64'(rd[0]), 64'hBBBB0003);
    nxt(); alloc = 1'b1; alloc_a = 0;
    nxt(); idle();
    @(negedge clk); check("alloc r0", 64'(busy), 64'h8);

    // Mid-cycle reset discards the presented write
    nxt(); we[0] = 1'b1; wa[0] = 9; wd[0] = 32'h00000099; alloc = 1'b1; alloc_a = 9;
    nxt(); idle(); ra[0] = 9;
    @(negedge clk); check("pre-reset rd9", 64'(rd[0]), 64'h99);
    check("pre-reset busy9", 64'(busy[9]), 64'h1);
    nxt(); we[0] = 1'b1; wa[0] = 9; wd[0] = 32'h55555555;
    #2 rst_n = 1'b0;
    #1;
    check("rst rd9", 64'(rd[0]), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst wcol", 64'(wcol), 64'h0);
    nxt(); idle(); rst_n = 1'b1;
    @(negedge clk); check("post-reset rd9", 64'(rd[0]), 64'h0);
    nxt();
    @(negedge clk); check("post-reset rd9 late", 64'(rd[0]), 64'h0);
    check("post-reset busy", 64'(busy), 64'h0);

    nxt();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, >= 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter NWR, default 2: number of write ports, 1..2.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ra  input  NRD x AW  read addresses.
REQ-008 SHALL have rd  output  NRD x XLEN  read data.
REQ-009 SHALL have rbusy  output  NRD  read register has a pending write.
REQ-010 SHALL have we  input  NWR  write enables.
REQ-011 SHALL have wa  input  NWR x AW  write addresses.
REQ-012 SHALL have wd  input  NWR x XLEN  write data.
REQ-013 SHALL have alloc  input  1  mark register alloc_a as pending-write (issue).
REQ-014 SHALL have alloc_a  input  AW  register to mark busy.
REQ-015 SHALL have busy  output  NREGS  scoreboard vector, bit i = register i pending.
REQ-016 SHALL have wcol  output  1  sticky write-collision flag.

Function
REQ-017 SHALL drive rd[p] combinationally from ra[p]; register 0 always reads 0.
REQ-018 SHALL bypass: if any we[k] targets ra[p] (nonzero) this cycle, rd[p] = that wd[k] (write-first); otherwise stored value.
REQ-019 SHALL commit wd[k] to wa[k] at rising edge when we[k]=1 and wa[k]!=0; writes to register 0 ignored.
REQ-020 SHALL, when both write ports target the same nonzero register in one cycle, commit and bypass port 1 data (higher index wins) and set wcol at that edge.
REQ-021 SHALL hold wcol at 1 until reset once set.
REQ-022 SHALL set busy[alloc_a] at rising edge when alloc=1 and alloc_a!=0.
REQ-023 SHALL clear busy[wa[k]] at rising edge when we[k]=1.
REQ-024 SHALL, on simultaneous alloc and write to the same register, leave busy set (new allocation wins) while still committing the data.
REQ-025 SHALL keep busy[0] = 0 permanently.
REQ-026 SHALL drive rbusy[p] = busy[ra[p]] AND NOT (any we[k] with wa[k]=ra[p] this cycle) -- i.e. a bypassed write resolves the hazard same cycle.
REQ-027 SHALL have zero-cycle read latency and one-cycle write latency (visible via storage the cycle after the edge, via bypass in the write cycle).

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear all registers to 0, busy to 0, wcol to 0.
REQ-029 SHALL, on reset mid-operation, discard any write or alloc presented in that cycle.
REQ-030 SHALL resume normal operation at the first rising edge with rst_n=1.

Structure
REQ-031 SHALL take default parameter constants (XLEN, NREGS, NRD, NWR) from shared package rf_pkg; AW derived locally.
REQ-032 SHALL instantiate one sub-module rf_scoreboard holding busy bits, alloc/clear logic and wcol.
REQ-033 SHALL keep storage and bypass muxing in reg_file_mp.

Verification
REQ-034 SHALL cover: reset, then read all ra -> rd=0, busy=0, wcol=0.
REQ-035 SHALL cover: we[0]=1, wa=5, wd=0xDEADBEEF, ra[0]=5 same cycle -> rd[0]=0xDEADBEEF bypassed; next cycle with we=0 -> rd[0]=0xDEADBEEF from storage.
REQ-036 SHALL cover: write wa=0 wd=0x12345678 -> rd for ra=0 stays 0 in both cycles, busy[0]=0.
REQ-037 SHALL cover: both ports write reg 7 (0x11111111 port 0, 0x22222222 port 1) -> rd=0x22222222, wcol=1 and stays 1 until reset.
REQ-038 SHALL cover: alloc reg 3 -> busy[3]=1, rbusy=1 for ra=3; write reg 3 -> rbusy=0 that cycle, busy[3]=0 after edge; alloc+write reg 3 same cycle -> busy[3]=1 after edge.
REQ-039 SHALL cover: rst_n low mid-cycle with we=1 wa=9 -> reg 9 reads 0 and busy cleared immediately, no write after release.
